// File: rtl/uart_rx_frame_if.sv
// Receive-word handshake between the UART receiver and its consumers.
// The receiver drives the word, its error flags and valid; the consumer drives ready.
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 parity_err;
  logic                 frame_err;

  modport master (
    output data,
    output valid,
    output parity_err,
    output frame_err,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  parity_err,
    input  frame_err,
    output ready
  );
endinterface

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: configurable width, parity and stop bits, per-frame
// parity/framing flags, sticky overrun, and a valid/ready output register.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | line idle, waiting for a falling edge on the synchronised line
// S_START  | qualifying the start bit at its centre
// S_DATA   | sampling data bits at bit centres, LSB first
// S_PARITY | sampling the parity bit
// S_STOP   | sampling stop bits; the word is loaded at the last one
// S_BREAK  | line still low after the frame, waiting for it to return high
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx_i,
  uart_rx_frame_if.master out_if,
  output logic            overrun_o,
  output logic            busy_o
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   CNT_MID   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   CNT_END   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [1:0]      LAST_STOP = 2'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state_q;
  logic [1:0]           sync_q;
  logic                 rx_prev_q;
  logic [CW-1:0]        cnt_q;
  logic [3:0]           bit_cnt_q;
  logic [1:0]           stop_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bit_q;
  logic                 stop_low_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 parity_err_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 busy_q;

  logic rx_s;
  logic mid_bit;
  logic bit_end;
  logic parity_err_d;
  logic frame_err_d;

  assign rx_s        = sync_q[1];
  assign mid_bit     = (cnt_q == CNT_MID);
  assign bit_end     = (cnt_q == CNT_END);
  assign frame_err_d = stop_low_q | ~rx_s;

  always_comb begin
    parity_err_d = 1'b0;
    if (PARITY == 1) begin
      parity_err_d = ^{shift_q, par_bit_q};
    end else if (PARITY == 2) begin
      parity_err_d = ~^{shift_q, par_bit_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sync_q       <= 2'b11;
      rx_prev_q    <= 1'b1;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      stop_low_q   <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      rx_prev_q <= rx_s;
      cnt_q     <= cnt_q + 1'b1;
      if (valid_q && out_if.ready) begin
        valid_q <= 1'b0;
      end

      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (rx_prev_q && !rx_s) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
          end
        end

        // Restarting the count at the start-bit centre puts every later bit end on a bit centre.
        S_START: begin
          if (mid_bit) begin
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            stop_low_q <= 1'b0;
            if (rx_s) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (bit_end) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_DATA) begin
              state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
            end
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            cnt_q     <= '0;
            par_bit_q <= rx_s;
            state_q   <= S_STOP;
          end
        end

        // A word arriving while the previous one is still unread is dropped, not overwritten.
        S_STOP: begin
          if (bit_end) begin
            cnt_q      <= '0;
            stop_cnt_q <= stop_cnt_q + 1'b1;
            if (!rx_s) begin
              stop_low_q <= 1'b1;
            end
            if (stop_cnt_q == LAST_STOP) begin
              if (valid_q && !out_if.ready) begin
                overrun_q <= 1'b1;
              end else begin
                data_q       <= shift_q;
                parity_err_q <= parity_err_d;
                frame_err_q  <= frame_err_d;
                valid_q      <= 1'b1;
              end
              if (rx_s) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_BREAK;
              end
            end
          end
        end

        S_BREAK: begin
          cnt_q <= '0;
          if (rx_s) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_if.data       = data_q;
  assign out_if.valid      = valid_q;
  assign out_if.parity_err = parity_err_q;
  assign out_if.frame_err  = frame_err_q;
  assign overrun_o         = overrun_q;
  assign busy_o            = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: four receivers (8N1, 8E1, 8O1, 5N2) driven with directed
// and random frames, checked against a frame-level reference model.
module tb_uart_rx_frame;
  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n   = 1'b0;
  logic       rst_n_d = 1'b0;
  logic [3:0] rx_line    = 4'hF;
  logic [3:0] ready_line = 4'hF;
  logic [3:0] ovr;
  logic [3:0] busy;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  uart_rx_frame_if #(.DATA_BITS(8)) if_a ();
  uart_rx_frame_if #(.DATA_BITS(8)) if_e ();
  uart_rx_frame_if #(.DATA_BITS(8)) if_o ();
  uart_rx_frame_if #(.DATA_BITS(5)) if_d ();

  assign if_a.ready = ready_line[0];
  assign if_e.ready = ready_line[1];
  assign if_o.ready = ready_line[2];
  assign if_d.ready = ready_line[3];

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_line[0]), .out_if(if_a), .overrun_o(ovr[0]), .busy_o(busy[0]));
  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_e (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_line[1]), .out_if(if_e), .overrun_o(ovr[1]), .busy_o(busy[1]));
  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_o (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_line[2]), .out_if(if_o), .overrun_o(ovr[2]), .busy_o(busy[2]));
  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_d (
    .clk(clk), .rst_n(rst_n_d), .rx_i(rx_line[3]), .out_if(if_d), .overrun_o(ovr[3]), .busy_o(busy[3]));

  logic [8:0] o_data [4];
  logic [3:0] o_valid, o_perr, o_ferr;
  assign o_data[0] = {1'b0, if_a.data};
  assign o_data[1] = {1'b0, if_e.data};
  assign o_data[2] = {1'b0, if_o.data};
  assign o_data[3] = {4'b0, if_d.data};
  assign o_valid   = {if_d.valid, if_o.valid, if_e.valid, if_a.valid};
  assign o_perr    = {if_d.parity_err, if_o.parity_err, if_e.parity_err, if_a.parity_err};
  assign o_ferr    = {if_d.frame_err, if_o.frame_err, if_e.frame_err, if_a.frame_err};

  // Every newly presented word (valid rise, or valid kept high right after an accept).
  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    int         cyc;
  } ev_t;
  ev_t        evq[$];
  logic [3:0] vprev   = 4'h0;
  logic [3:0] accprev = 4'h0;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (o_valid[i] && (!vprev[i] || accprev[i])) begin
        evq.push_back('{i, o_data[i], o_perr[i], o_ferr[i], cyc});
      end
    end
    vprev   <= o_valid;
    accprev <= o_valid & ready_line;
  end

  // Frame-level reference model.
  logic [3:0] mdl_valid = 4'h0;
  logic [3:0] mdl_ovr   = 4'h0;
  logic [8:0] mdl_data [4];
  int         t_start  [4];

  function automatic int nb(input int inst);
    return (inst == 3) ? 5 : 8;
  endfunction
  function automatic int pm(input int inst);
    return (inst == 1) ? 1 : (inst == 2) ? 2 : 0;
  endfunction
  function automatic int ns(input int inst);
    return (inst == 3) ? 2 : 1;
  endfunction

  function automatic logic ref_perr(input int inst, input logic [8:0] d, input logic p);
    int ones;
    ones = $countones(d) + int'(p);
    if (pm(inst) == 0) return 1'b0;
    if (pm(inst) == 1) return (ones % 2) != 0;
    return (ones % 2) == 0;
  endfunction

  function automatic int find_ev(input int inst);
    foreach (evq[k]) if (evq[k].inst == inst) return k;
    return -1;
  endfunction

  function automatic int count_ev(input int inst);
    int n = 0;
    foreach (evq[k]) if (evq[k].inst == inst) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int inst, input string tag);
    chk({tag, "_data"},  o_data[inst],  0);
    chk({tag, "_valid"}, o_valid[inst], 0);
    chk({tag, "_perr"},  o_perr[inst],  0);
    chk({tag, "_ferr"},  o_ferr[inst],  0);
    chk({tag, "_ovr"},   ovr[inst],     0);
    chk({tag, "_busy"},  busy[inst],    0);
  endtask

  task automatic send_raw(input int inst, input logic [8:0] dat, input logic par, input logic stop_val);
    @(posedge clk); #1;
    t_start[inst]  = cyc;
    rx_line[inst]  = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int b = 0; b < nb(inst); b++) begin
      rx_line[inst] = dat[b];
      repeat (CPB) @(posedge clk);
      #1;
    end
    if (pm(inst) != 0) begin
      rx_line[inst] = par;
      repeat (CPB) @(posedge clk);
      #1;
    end
    for (int s = 0; s < ns(inst); s++) begin
      rx_line[inst] = stop_val;
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_word(input int inst, input logic [8:0] d, input logic pe, input logic fe,
                             input string tag);
    int  k;
    int  lat;
    int  le;
    ev_t ev;
    k = find_ev(inst);
    for (int w = 0; w < 4 * CPB && k < 0; w++) begin
      @(negedge clk);
      k = find_ev(inst);
    end
    chk({tag, "_word_seen"}, k >= 0, 1);
    if (k >= 0) begin
      ev = evq[k];
      evq.delete(k);
      chk({tag, "_data"}, ev.data, d);
      chk({tag, "_perr"}, ev.perr, pe);
      chk({tag, "_ferr"}, ev.ferr, fe);
      lat = ev.cyc - t_start[inst];
      le  = 3 + (1 + nb(inst) + ((pm(inst) != 0) ? 1 : 0) + ns(inst)) * CPB - CPB / 2;
      vectors++;
      assert (lat >= le - 1 && lat <= le + 1) else begin
        miscompares++;
        $error("FAIL %s_latency: observed %0d cycles, expected %0d +/-1", tag, lat, le);
      end
    end
  endtask

  task automatic xfer(input int inst, input logic [8:0] dat, input logic par, input logic stop_val,
                      input string tag);
    logic [8:0] d;
    d = dat & 9'((1 << nb(inst)) - 1);
    send_raw(inst, dat, par, stop_val);
    if (!mdl_valid[inst] || ready_line[inst]) begin
      expect_word(inst, d, ref_perr(inst, d, par), !stop_val, tag);
      mdl_valid[inst] = !ready_line[inst];
      mdl_data[inst]  = d;
      if (ready_line[inst]) chk({tag, "_valid_drop"}, o_valid[inst], 0);
    end else begin
      mdl_ovr[inst] = 1'b1;
      repeat (2) @(negedge clk);
      chk({tag, "_no_new_word"}, count_ev(inst), 0);
      chk({tag, "_held_data"}, o_data[inst], mdl_data[inst]);
    end
    chk({tag, "_ovr"}, ovr[inst], mdl_ovr[inst]);
  endtask

  initial begin
    #900000;
    miscompares++;
    $display("FAIL watchdog: observed no end of run, expected completion before 900000 ns");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] r;
    logic       sv;

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk_idle(i, $sformatf("reset%0d", i));
    rst_n   = 1'b1;
    rst_n_d = 1'b1;
    repeat (5) @(posedge clk);

    xfer(0, 9'h41, 1'b0, 1'b1, "a_41");
    chk("a_41_single_pulse", count_ev(0), 0);

    xfer(1, 9'h03, 1'b0, 1'b1, "e_03_p0");
    xfer(1, 9'h03, 1'b1, 1'b1, "e_03_p1");
    xfer(2, 9'h03, 1'b1, 1'b1, "o_03_p1");
    xfer(2, 9'h03, 1'b0, 1'b1, "o_03_p0");

    // Stop bit low, line held low: break.
    xfer(0, 9'h55, 1'b0, 1'b0, "a_brk55");
    repeat (20 * CPB) @(posedge clk);
    #1;
    chk("a_brk_busy", busy[0], 1);
    repeat (20 * CPB) @(posedge clk);
    #1;
    chk("a_brk_no_frame", count_ev(0), 0);
    rx_line[0] = 1'b1;
    repeat (8) @(negedge clk);
    chk("a_brk_busy_clear", busy[0], 0);
    xfer(0, 9'h0A, 1'b0, 1'b1, "a_0A");

    // Short low glitch.
    @(posedge clk); #1;
    rx_line[0] = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    #1;
    rx_line[0] = 1'b1;
    @(negedge clk);
    chk("glitch_busy", busy[0], 1);
    repeat (3 * CPB) @(negedge clk);
    chk("glitch_idle", busy[0], 0);
    chk("glitch_no_word", count_ev(0), 0);
    xfer(0, 9'h7E, 1'b0, 1'b1, "a_7E");

    for (int i = 0; i < 6; i++) begin
      r  = 9'($urandom_range(0, 255));
      sv = ($urandom_range(0, 3) != 0);
      xfer(0, r, 1'b0, sv, "rand_a");
      if (!sv) begin
        rx_line[0] = 1'b1;
        repeat (3 * CPB) @(posedge clk);
      end
      xfer(1, 9'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1, "rand_e");
      xfer(2, 9'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1, "rand_o");
      xfer(3, 9'($urandom_range(0, 31)), 1'b0, 1'b1, "rand_d");
    end

    // Overrun: unread word kept, later word dropped.
    ready_line[0] = 1'b0;
    xfer(0, 9'h31, 1'b0, 1'b1, "ovr_31");
    xfer(0, 9'h32, 1'b0, 1'b1, "ovr_32");
    @(posedge clk); #1;
    ready_line[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("ovr_accept_valid", o_valid[0], 0);
    mdl_valid[0] = 1'b0;
    xfer(0, 9'h33, 1'b0, 1'b1, "ovr_33");

    // 5N2, then reset in the middle of a frame.
    ready_line[3] = 1'b0;
    xfer(3, 9'h15, 1'b0, 1'b1, "d_15");
    chk("d_15_held", o_valid[3], 1);
    fork
      send_raw(3, 9'h1C, 1'b0, 1'b1);
      begin
        repeat (CPB * 5 / 2) @(posedge clk);
        #1;
        chk("d_mid_busy", busy[3], 1);
        rst_n_d = 1'b0;
        #2;
        chk_idle(3, "d_midrst");
        repeat (CPB) @(posedge clk);
        #1;
        rst_n_d = 1'b1;
      end
    join
    mdl_valid[3] = 1'b0;
    mdl_ovr[3]   = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    chk("d_after_rst_no_word", count_ev(3), 0);
    chk("d_after_rst_busy", busy[3], 0);
    ready_line[3] = 1'b1;
    xfer(3, 9'h0F, 1'b0, 1'b1, "d_0F");

    repeat (10) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
